// File: rtl/alu_seq_if.sv
// ============================================================================
//  Module      : alu_seq_if
//  Description : Controller <-> ALU handshake, operand and flag signals.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface alu_seq_if #(
  parameter int WIDTH = 8
) ();
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_op;
  logic             alu_start;
  logic             alu_out;
  logic [WIDTH-1:0] alu_hi;
  logic             alu_cy;
  logic             alu_z;
  logic             alu_n;
  logic             alu_v;
  logic             alu_busy;
  logic             alu_done;

  modport master (
    output alu_a, alu_b, alu_op, alu_start, alu_out,
    input  alu_hi, alu_cy, alu_z, alu_n, alu_v, alu_busy, alu_done
  );

  modport slave (
    input  alu_a, alu_b, alu_op, alu_start, alu_out,
    output alu_hi, alu_cy, alu_z, alu_n, alu_v, alu_busy, alu_done
  );
endinterface

`default_nettype wire

// File: rtl/alu_seq.sv
// ============================================================================
//  Module      : alu_seq
//  Description : Registered opcode ALU with flags and shift-add multiplier.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_seq #(
  parameter int WIDTH  = 8,
  parameter bit MUL_EN = 1'b1
) (
  input  wire logic             clk,
  input  wire logic             rst,
  alu_seq_if.slave              alu,
  output wire logic [WIDTH-1:0] alu_bus
);

  localparam int         c_MSB   = WIDTH - 1;
  localparam int         c_CNT_W = $clog2(WIDTH + 1);
  localparam logic [2:0] c_OP_ADD = 3'b000;
  localparam logic [2:0] c_OP_SUB = 3'b001;
  localparam logic [2:0] c_OP_AND = 3'b010;
  localparam logic [2:0] c_OP_OR  = 3'b011;
  localparam logic [2:0] c_OP_XOR = 3'b100;
  localparam logic [2:0] c_OP_SHL = 3'b101;
  localparam logic [2:0] c_OP_SHR = 3'b110;
  localparam logic [2:0] c_OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [2:0]         r_op;
  logic [WIDTH-1:0]   r_result;
  logic [WIDTH-1:0]   r_hi;
  logic               r_cy;
  logic               r_z;
  logic               r_n;
  logic               r_v;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_mhi;
  logic [WIDTH-1:0]   r_mlo;
  logic [c_CNT_W-1:0] r_cnt;

  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_dif;
  logic [WIDTH:0]     w_madd;
  logic [WIDTH-1:0]   w_res;
  logic               w_cy;
  logic               w_v;

  always_comb begin
    w_sum = {1'b0, r_a} + {1'b0, r_b};
    w_dif = {1'b0, r_a} - {1'b0, r_b};
    w_res = '0;
    w_cy  = 1'b0;
    w_v   = 1'b0;
    case (r_op)
      c_OP_ADD: begin
        w_res = w_sum[c_MSB:0];
        w_cy  = w_sum[WIDTH];
        w_v   = (r_a[c_MSB] == r_b[c_MSB]) && (w_sum[c_MSB] != r_a[c_MSB]);
      end
      c_OP_SUB: begin
        w_res = w_dif[c_MSB:0];
        w_cy  = w_dif[WIDTH];
        w_v   = (r_a[c_MSB] != r_b[c_MSB]) && (w_dif[c_MSB] != r_a[c_MSB]);
      end
      c_OP_AND: w_res = r_a & r_b;
      c_OP_OR:  w_res = r_a | r_b;
      c_OP_XOR: w_res = r_a ^ r_b;
      c_OP_SHL: begin
        w_res = {r_a[c_MSB-1:0], 1'b0};
        w_cy  = r_a[c_MSB];
      end
      c_OP_SHR: begin
        w_res = {1'b0, r_a[c_MSB:1]};
        w_cy  = r_a[0];
      end
      default: ;
    endcase
  end

  // One shift-add step: conditionally add the multiplicand, then shift {hi,lo} right.
  assign w_madd = {1'b0, r_mhi} + (r_mlo[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_result <= '0;
      r_hi     <= '0;
      r_cy     <= 1'b0;
      r_z      <= 1'b0;
      r_n      <= 1'b0;
      r_v      <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_mhi    <= '0;
      r_mlo    <= '0;
      r_cnt    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (alu.alu_start) begin
            r_a    <= alu.alu_a;
            r_b    <= alu.alu_b;
            r_op   <= alu.alu_op;
            r_busy <= 1'b1;
            if ((alu.alu_op == c_OP_MUL) && MUL_EN) begin
              r_state <= S_MUL;
              r_mhi   <= '0;
              r_mlo   <= alu.alu_b;
              r_cnt   <= '0;
            end else begin
              r_state <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          r_state <= S_DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          // Only reachable with op 111 when the multiplier is disabled: a pure NOP.
          if (r_op != c_OP_MUL) begin
            r_result <= w_res;
            r_hi     <= '0;
            r_cy     <= w_cy;
            r_z      <= (w_res == '0);
            r_n      <= w_res[c_MSB];
            r_v      <= w_v;
          end
        end
        S_MUL: begin
          if (r_cnt == c_CNT_W'(WIDTH)) begin
            r_state  <= S_DONE;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_result <= r_mlo;
            r_hi     <= r_mhi;
            r_cy     <= |r_mhi;
            r_z      <= (r_mlo == '0);
            r_n      <= r_mlo[c_MSB];
            r_v      <= 1'b0;
          end else begin
            r_mhi <= w_madd[WIDTH:1];
            r_mlo <= {w_madd[0], r_mlo[c_MSB:1]};
            r_cnt <= r_cnt + c_CNT_W'(1);
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign alu.alu_hi   = r_hi;
  assign alu.alu_cy   = r_cy;
  assign alu.alu_z    = r_z;
  assign alu.alu_n    = r_n;
  assign alu.alu_v    = r_v;
  assign alu.alu_busy = r_busy;
  assign alu.alu_done = r_done;
  assign alu_bus      = alu.alu_out ? r_result : {WIDTH{1'bz}};

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
// ============================================================================
//  Module      : tb_alu_seq
//  Description : Directed vector bench for alu_seq (8-bit MUL and 16-bit no-MUL).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(8))  u_if8 ();
  alu_seq_if #(.WIDTH(16)) u_if16 ();
  wire [7:0]  w_bus8;
  wire [15:0] w_bus16;

  alu_seq #(.WIDTH(8), .MUL_EN(1'b1)) u_dut8 (
    .clk     (clk),
    .rst     (rst),
    .alu     (u_if8),
    .alu_bus (w_bus8)
  );

  alu_seq #(.WIDTH(16), .MUL_EN(1'b0)) u_dut16 (
    .clk     (clk),
    .rst     (rst),
    .alu     (u_if16),
    .alu_bus (w_bus16)
  );

  typedef struct {
    bit          sel;   // 0: 8-bit DUT, 1: 16-bit DUT
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  op;
    logic [15:0] res;
    logic [15:0] hi;
    logic [3:0]  flg;   // {cy, z, n, v}
    int          lat;
  } vec_t;

  int total = 0;
  int bad   = 0;
  vec_t vecs[$];

  function automatic logic [15:0] f_bus(input bit sel);
    return sel ? w_bus16 : {8'h00, w_bus8};
  endfunction
  function automatic logic [15:0] f_hi(input bit sel);
    return sel ? u_if16.alu_hi : {8'h00, u_if8.alu_hi};
  endfunction
  function automatic logic [3:0] f_flg(input bit sel);
    return sel ? {u_if16.alu_cy, u_if16.alu_z, u_if16.alu_n, u_if16.alu_v}
               : {u_if8.alu_cy, u_if8.alu_z, u_if8.alu_n, u_if8.alu_v};
  endfunction
  function automatic logic f_done(input bit sel);
    return sel ? u_if16.alu_done : u_if8.alu_done;
  endfunction
  function automatic logic f_busy(input bit sel);
    return sel ? u_if16.alu_busy : u_if8.alu_busy;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic [15:0] a, input logic [15:0] b,
                       input logic [2:0] op, input logic st);
    if (sel) begin
      u_if16.alu_a = a; u_if16.alu_b = b; u_if16.alu_op = op; u_if16.alu_start = st;
    end else begin
      u_if8.alu_a = a[7:0]; u_if8.alu_b = b[7:0]; u_if8.alu_op = op; u_if8.alu_start = st;
    end
  endtask

  // Called at the negedge after the accepting edge; lat counts edges since then.
  task automatic wait_done(input bit sel, output int lat, output bit seen);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat <= 40) begin
      if (f_done(sel)) seen = 1'b1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int    lat;
    bit    seen;
    string t;
    t = $sformatf("v%0d", idx);
    drive(v.sel, v.a, v.b, v.op, 1'b1);
    @(posedge clk);
    @(negedge clk);
    drive(v.sel, ~v.a, ~v.b, v.op ^ 3'b011, 1'b0);
    chk({t, " busy_in_flight"}, 32'(f_busy(v.sel)), 32'd1);
    wait_done(v.sel, lat, seen);
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL %s timeout: got no done want done", t);
      return;
    end
    chk({t, " latency"}, lat, v.lat);
    chk({t, " bus"}, 32'(f_bus(v.sel)), 32'(v.res));
    chk({t, " hi"}, 32'(f_hi(v.sel)), 32'(v.hi));
    chk({t, " flags"}, 32'(f_flg(v.sel)), 32'(v.flg));
    chk({t, " busy_at_done"}, 32'(f_busy(v.sel)), 32'd0);
    @(negedge clk);
    chk({t, " done_pulse"}, 32'(f_done(v.sel)), 32'd0);
  endtask

  initial begin
    int  lat;
    bit  seen;
    int  cnt;

    //            sel a        b        op      res      hi       cy z n v lat
    vecs.push_back('{0, 16'd10,  16'd10,  3'b000, 16'd20,  16'h00, 4'b0000, 1});
    vecs.push_back('{0, 16'd200, 16'd100, 3'b000, 16'd44,  16'h00, 4'b1000, 1});
    vecs.push_back('{0, 16'd100, 16'd200, 3'b001, 16'd156, 16'h00, 4'b1011, 1});
    vecs.push_back('{0, 16'd10,  16'd10,  3'b001, 16'd0,   16'h00, 4'b0100, 1});
    vecs.push_back('{0, 16'd127, 16'd1,   3'b000, 16'd128, 16'h00, 4'b0011, 1});
    vecs.push_back('{0, 16'd128, 16'd1,   3'b001, 16'd127, 16'h00, 4'b0001, 1});
    vecs.push_back('{0, 16'h81,  16'h55,  3'b101, 16'h02,  16'h00, 4'b1000, 1});
    vecs.push_back('{0, 16'h81,  16'h55,  3'b110, 16'h40,  16'h00, 4'b1000, 1});
    vecs.push_back('{0, 16'hF0,  16'h3C,  3'b010, 16'h30,  16'h00, 4'b0000, 1});
    vecs.push_back('{0, 16'hF0,  16'h0C,  3'b011, 16'hFC,  16'h00, 4'b0010, 1});
    vecs.push_back('{0, 16'hAA,  16'hAA,  3'b100, 16'h00,  16'h00, 4'b0100, 1});
    vecs.push_back('{0, 16'd200, 16'd100, 3'b111, 16'h20,  16'h4E, 4'b1000, 9});
    vecs.push_back('{0, 16'hFF,  16'h01,  3'b000, 16'h00,  16'h00, 4'b1100, 1});
    vecs.push_back('{0, 16'd15,  16'd17,  3'b111, 16'hFF,  16'h00, 4'b0010, 9});
    vecs.push_back('{0, 16'h00,  16'hAB,  3'b111, 16'h00,  16'h00, 4'b0100, 9});
    vecs.push_back('{0, 16'hFF,  16'hFF,  3'b111, 16'h01,  16'hFE, 4'b1000, 9});
    vecs.push_back('{0, 16'h01,  16'h00,  3'b110, 16'h00,  16'h00, 4'b1100, 1});
    vecs.push_back('{0, 16'h40,  16'h00,  3'b101, 16'h80,  16'h00, 4'b0010, 1});
    vecs.push_back('{1, 16'd10,  16'd10,  3'b000, 16'd20,  16'h00, 4'b0000, 1});
    vecs.push_back('{1, 16'd5,   16'd7,   3'b111, 16'd20,  16'h00, 4'b0000, 1});
    vecs.push_back('{1, 16'hFFFF,16'h0001,3'b000, 16'h0000,16'h00, 4'b1100, 1});
    vecs.push_back('{1, 16'd3,   16'd9,   3'b111, 16'h0000,16'h00, 4'b1100, 1});
    vecs.push_back('{1, 16'h8000,16'h0001,3'b001, 16'h7FFF,16'h00, 4'b0001, 1});

    rst = 1'b1;
    drive(0, 16'h0, 16'h0, 3'b000, 1'b0);
    drive(1, 16'h0, 16'h0, 3'b000, 1'b0);
    u_if8.alu_out  = 1'b1;
    u_if16.alu_out = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    chk("reset bus", 32'(f_bus(0)), 32'd0);
    chk("reset hi", 32'(f_hi(0)), 32'd0);
    chk("reset flags", 32'(f_flg(0)), 32'd0);
    chk("reset busy", 32'(f_busy(0)), 32'd0);
    chk("reset done", 32'(f_done(0)), 32'd0);
    chk("reset bus16", 32'(f_bus(1)), 32'd0);

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Start pulse while multiplying must be dropped; bus/hi keep the old result.
    drive(0, 16'd200, 16'd100, 3'b111, 1'b1);
    @(posedge clk);
    @(negedge clk);
    drive(0, 16'd0, 16'd0, 3'b000, 1'b0);
    @(negedge clk);
    @(negedge clk);
    drive(0, 16'd1, 16'd1, 3'b000, 1'b1);
    chk("busy bus_prev", 32'(f_bus(0)), 32'h80);
    chk("busy hi_prev", 32'(f_hi(0)), 32'h00);
    @(negedge clk);
    drive(0, 16'd0, 16'd0, 3'b000, 1'b0);
    wait_done(0, lat, seen);
    chk("ign seen", 32'(seen), 32'd1);
    chk("ign latency", lat + 3, 9);
    chk("ign bus", 32'(f_bus(0)), 32'h20);
    chk("ign hi", 32'(f_hi(0)), 32'h4E);
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (f_done(0)) cnt++;
      if (f_busy(0)) cnt++;
    end
    chk("ign no_queued_op", cnt, 0);

    // Held start re-triggers every three cycles: done after N+1, N+4, N+7.
    drive(0, 16'd1, 16'd2, 3'b000, 1'b1);
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (f_done(0)) cnt++;
    end
    drive(0, 16'd0, 16'd0, 3'b000, 1'b0);
    chk("held done_count", cnt, 3);
    repeat (4) @(negedge clk);
    chk("held bus", 32'(f_bus(0)), 32'd3);

    // Reset during the 4th multiply iteration.
    drive(0, 16'd3, 16'd5, 3'b111, 1'b1);
    @(posedge clk);
    @(negedge clk);
    drive(0, 16'd0, 16'd0, 3'b000, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid busy", 32'(f_busy(0)), 32'd0);
    chk("rstmid done", 32'(f_done(0)), 32'd0);
    chk("rstmid flags", 32'(f_flg(0)), 32'd0);
    chk("rstmid hi", 32'(f_hi(0)), 32'd0);
    chk("rstmid bus", 32'(f_bus(0)), 32'd0);
    rst = 1'b0;
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (f_done(0)) cnt++;
    end
    chk("rstmid no_done", cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
